wb_regfile: RTL and testbench



---
 rtl/wb_regfile_pkg.sv | 62 ++++++
 rtl/wb_regfile_gpr_bank.sv | 30 +++
 rtl/wb_regfile.sv | 124 ++++++++++++
 tb/tb_wb_regfile.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared encodings, widths and helpers for the writeback stage / register file.
// Decoder control encodings live here so decode and writeback agree on them.
package wb_regfile_pkg;

  localparam int DATA_W       = 16;
  localparam int INST_W       = 16;
  localparam int REG_OP_W     = 3;
  localparam int WB_DATA_OP_W = 3;
  localparam int WB_ADDR_OP_W = 2;
  localparam int GPR_NUM      = 8;
  localparam int GPR_IDX_W    = 3;

  // LSB positions of the register fields inside the instruction word
  localparam int INST_RX = 8;
  localparam int INST_RY = 5;
  localparam int INST_RZ = 2;

  typedef enum logic [REG_OP_W-1:0] {
    REG_OP_NOP = 3'd0,
    REG_OP_REG = 3'd1,
    REG_OP_SP  = 3'd2,
    REG_OP_IH  = 3'd3,
    REG_OP_T   = 3'd4
  } reg_op_e;

  typedef enum logic [WB_DATA_OP_W-1:0] {
    WB_DATA_OP_NOP = 3'd0,
    WB_DATA_OP_ALU = 3'd1,
    WB_DATA_OP_MEM = 3'd2,
    WB_DATA_OP_IH  = 3'd3,
    WB_DATA_OP_PC  = 3'd4
  } wb_data_op_e;

  typedef enum logic [WB_ADDR_OP_W-1:0] {
    WB_ADDR_OP_NOP = 2'd0,
    WB_ADDR_OP_RX  = 2'd1,
    WB_ADDR_OP_RY  = 2'd2,
    WB_ADDR_OP_RZ  = 2'd3
  } wb_addr_op_e;

  typedef struct packed {
    logic [DATA_W-1:0]    value;
    logic [REG_OP_W-1:0]  target;
    logic [GPR_IDX_W-1:0] idx;
  } wb_entry_t;

  // Illegal REG decode with no address source falls through to R0.
  function automatic logic [GPR_IDX_W-1:0] sel_gpr_idx(
    input logic [GPR_IDX_W-1:0]    rx,
    input logic [GPR_IDX_W-1:0]    ry,
    input logic [GPR_IDX_W-1:0]    rz,
    input logic [WB_ADDR_OP_W-1:0] addr_op
  );
    case (addr_op)
      WB_ADDR_OP_RX: return rx;
      WB_ADDR_OP_RY: return ry;
      WB_ADDR_OP_RZ: return rz;
      default:       return '0;
    endcase
  endfunction

endpackage

// File: rtl/wb_regfile_gpr_bank.sv
// 8x16 general purpose register storage: one synchronous write port and two
// combinational read ports, cleared by the synchronous active-low reset.
module gpr_bank
  import wb_regfile_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [GPR_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [GPR_IDX_W-1:0] i_raddr_a,
  input  logic [GPR_IDX_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0]    o_rdata_a,
  output logic [DATA_W-1:0]    o_rdata_b
);

  logic [DATA_W-1:0] r_mem [GPR_NUM];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < GPR_NUM; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: one-entry WB register feeding R0-R7, SP, IH and T.
// Define WB_BYPASS_EN to forward the pending WB value onto the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                    clk_50MHz,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [INST_W-1:0]       inst,
  input  logic [REG_OP_W-1:0]     REG_op,
  input  logic [WB_DATA_OP_W-1:0] wb_data_op,
  input  logic [WB_ADDR_OP_W-1:0] wb_addr_op,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic [DATA_W-1:0]       pc,
  input  logic [GPR_IDX_W-1:0]    ra_addr,
  input  logic [GPR_IDX_W-1:0]    rb_addr,
  output logic [DATA_W-1:0]       ra_data,
  output logic [DATA_W-1:0]       rb_data,
  output logic [DATA_W-1:0]       sp_data,
  output logic [DATA_W-1:0]       ih_data,
  output logic [DATA_W-1:0]       t_data,
  output logic                    wb_pending,
  output logic [DATA_W-1:0]       retire_cnt
);

  wb_entry_t         r_wb;
  logic              r_pending;
  logic [DATA_W-1:0] r_sp;
  logic [DATA_W-1:0] r_ih;
  logic [DATA_W-1:0] r_t;
  logic [DATA_W-1:0] r_retire;

  logic [GPR_IDX_W-1:0] w_rx, w_ry, w_rz;
  logic                 w_unused_inst;
  logic                 w_capture;
  logic                 w_commit;
  logic                 w_gpr_we;
  wb_entry_t            w_wb_next;
  logic [DATA_W-1:0]    w_ra_gpr, w_rb_gpr;

  assign w_rx = inst[INST_RX +: GPR_IDX_W];
  assign w_ry = inst[INST_RY +: GPR_IDX_W];
  assign w_rz = inst[INST_RZ +: GPR_IDX_W];
  assign w_unused_inst = ^{inst[INST_W-1:INST_RX+GPR_IDX_W], inst[INST_RZ-1:0]};

  assign w_capture = valid_in & ~stall & ~flush &
                     (REG_op != REG_OP_NOP) & (wb_data_op != WB_DATA_OP_NOP);
  assign w_commit  = r_pending & ~stall & ~flush;
  assign w_gpr_we  = w_commit & (r_wb.target == REG_OP_REG);

  always_comb begin
    w_wb_next        = '0;
    w_wb_next.target = REG_op;
    case (wb_data_op)
      WB_DATA_OP_ALU: w_wb_next.value = alu_result;
      WB_DATA_OP_MEM: w_wb_next.value = mem_data;
      WB_DATA_OP_IH:  w_wb_next.value = ih_data;
      WB_DATA_OP_PC:  w_wb_next.value = pc;
      default:        w_wb_next.value = '0;
    endcase
    if (REG_op == REG_OP_REG) w_wb_next.idx = sel_gpr_idx(w_rx, w_ry, w_rz, wb_addr_op);
  end

  // flush beats stall, commit and capture; stall freezes everything else
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      r_wb      <= '0;
      r_pending <= 1'b0;
      r_sp      <= '0;
      r_ih      <= '0;
      r_t       <= '0;
      r_retire  <= '0;
    end else if (flush) begin
      r_pending <= 1'b0;
    end else if (!stall) begin
      if (r_pending) begin
        case (r_wb.target)
          REG_OP_SP: r_sp <= r_wb.value;
          REG_OP_IH: r_ih <= r_wb.value;
          REG_OP_T:  r_t  <= r_wb.value;
          default: ;
        endcase
        r_retire <= r_retire + 16'd1;
      end
      r_pending <= w_capture;
      if (w_capture) r_wb <= w_wb_next;
    end
  end

  gpr_bank u_gpr_bank (
    .i_clk     (clk_50MHz),
    .i_rst_n   (rst),
    .i_we      (w_gpr_we),
    .i_waddr   (r_wb.idx),
    .i_wdata   (r_wb.value),
    .i_raddr_a (ra_addr),
    .i_raddr_b (rb_addr),
    .o_rdata_a (w_ra_gpr),
    .o_rdata_b (w_rb_gpr)
  );

`ifdef WB_BYPASS_EN
  logic w_byp_reg;
  assign w_byp_reg = r_pending & (r_wb.target == REG_OP_REG);
  assign ra_data = (w_byp_reg && r_wb.idx == ra_addr) ? r_wb.value : w_ra_gpr;
  assign rb_data = (w_byp_reg && r_wb.idx == rb_addr) ? r_wb.value : w_rb_gpr;
  assign sp_data = (r_pending && r_wb.target == REG_OP_SP) ? r_wb.value : r_sp;
  assign ih_data = (r_pending && r_wb.target == REG_OP_IH) ? r_wb.value : r_ih;
  assign t_data  = (r_pending && r_wb.target == REG_OP_T)  ? r_wb.value : r_t;
`else
  assign ra_data = w_ra_gpr;
  assign rb_data = w_rb_gpr;
  assign sp_data = r_sp;
  assign ih_data = r_ih;
  assign t_data  = r_t;
`endif

  assign wb_pending = r_pending;
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations follow the WB_BYPASS_EN setting.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_50MHz = 1'b0;
  logic        rst;
  logic        valid_in, stall, flush;
  logic [15:0] inst;
  logic [2:0]  REG_op;
  logic [2:0]  wb_data_op;
  logic [1:0]  wb_addr_op;
  logic [15:0] alu_result, mem_data, pc;
  logic [2:0]  ra_addr, rb_addr;
  logic [15:0] ra_data, rb_data, sp_data, ih_data, t_data, retire_cnt;
  logic        wb_pending;

  int checks = 0;
  int fails  = 0;
  int exp_retire = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  wb_regfile dut (
    .clk_50MHz (clk_50MHz), .rst (rst), .valid_in (valid_in), .stall (stall),
    .flush (flush), .inst (inst), .REG_op (REG_op), .wb_data_op (wb_data_op),
    .wb_addr_op (wb_addr_op), .alu_result (alu_result), .mem_data (mem_data),
    .pc (pc), .ra_addr (ra_addr), .rb_addr (rb_addr), .ra_data (ra_data),
    .rb_data (rb_data), .sp_data (sp_data), .ih_data (ih_data), .t_data (t_data),
    .wb_pending (wb_pending), .retire_cnt (retire_cnt)
  );

  task automatic tick;
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic idle;
    valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    inst = '0; REG_op = REG_OP_NOP; wb_data_op = WB_DATA_OP_NOP; wb_addr_op = WB_ADDR_OP_NOP;
    alu_result = '0; mem_data = '0; pc = '0;
  endtask

  task automatic issue(input logic [2:0] rop, input logic [2:0] dop, input logic [1:0] aop,
                       input logic [15:0] i_w, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [15:0] p);
    valid_in = 1'b1; stall = 1'b0; flush = 1'b0;
    REG_op = rop; wb_data_op = dop; wb_addr_op = aop; inst = i_w;
    alu_result = alu; mem_data = mem; pc = p;
  endtask

  task automatic test_reset;
    rst = 1'b0; idle(); ra_addr = 3'd0; rb_addr = 3'd7;
    tick(); tick();
    rst = 1'b1;
    checks++; if (wb_pending !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b exp=0", wb_pending); end
    checks++; if (retire_cnt !== 16'h0) begin fails++; $display("FAIL reset_retire got=%h exp=0000", retire_cnt); end
    checks++; if ({ra_data, rb_data} !== 32'h0) begin fails++; $display("FAIL reset_gpr got=%h exp=00000000", {ra_data, rb_data}); end
    checks++; if ({sp_data, ih_data, t_data} !== 48'h0) begin fails++; $display("FAIL reset_special got=%h exp=0", {sp_data, ih_data, t_data}); end
  endtask

  task automatic test_addu;
    ra_addr = 3'd3;
    issue(REG_OP_REG, WB_DATA_OP_ALU, WB_ADDR_OP_RZ, 16'h000C, 16'h1234, 16'h0, 16'h0);
    tick(); idle();
    checks++; if (wb_pending !== 1'b1) begin fails++; $display("FAIL addu_pending got=%b exp=1", wb_pending); end
    checks++; if (ra_data !== (BYP ? 16'h1234 : 16'h0000)) begin fails++; $display("FAIL addu_capture got=%h exp=%h", ra_data, BYP ? 16'h1234 : 16'h0000); end
    tick(); exp_retire++;
    checks++; if (ra_data !== 16'h1234) begin fails++; $display("FAIL addu_commit got=%h exp=1234", ra_data); end
    checks++; if (retire_cnt !== 16'(exp_retire)) begin fails++; $display("FAIL addu_retire got=%h exp=%h", retire_cnt, 16'(exp_retire)); end
    checks++; if (wb_pending !== 1'b0) begin fails++; $display("FAIL addu_pending_clr got=%b exp=0", wb_pending); end
  endtask

  task automatic test_lw;
    ra_addr = 3'd5; rb_addr = 3'd3;
    issue(REG_OP_REG, WB_DATA_OP_MEM, WB_ADDR_OP_RY, 16'h00A0, 16'hDEAD, 16'hBEEF, 16'h0);
    tick(); idle();
    checks++; if (ra_data !== (BYP ? 16'hBEEF : 16'h0000)) begin fails++; $display("FAIL lw_capture got=%h exp=%h", ra_data, BYP ? 16'hBEEF : 16'h0000); end
    checks++; if (rb_data !== 16'h1234) begin fails++; $display("FAIL lw_other_reg got=%h exp=1234", rb_data); end
    tick(); exp_retire++;
    checks++; if (ra_data !== 16'hBEEF) begin fails++; $display("FAIL lw_commit got=%h exp=beef", ra_data); end
  endtask

  task automatic test_sp_back_to_back;
    issue(REG_OP_SP, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h0, 16'h7F00, 16'h0, 16'h0);
    tick();
    checks++; if (sp_data !== (BYP ? 16'h7F00 : 16'h0000)) begin fails++; $display("FAIL sp_first_capture got=%h exp=%h", sp_data, BYP ? 16'h7F00 : 16'h0000); end
    issue(REG_OP_SP, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h0, 16'h7F10, 16'h0, 16'h0);
    tick(); idle(); exp_retire++;
    checks++; if (sp_data !== (BYP ? 16'h7F10 : 16'h7F00)) begin fails++; $display("FAIL sp_second_capture got=%h exp=%h", sp_data, BYP ? 16'h7F10 : 16'h7F00); end
    checks++; if (wb_pending !== 1'b1) begin fails++; $display("FAIL sp_overlap_pending got=%b exp=1", wb_pending); end
    tick(); exp_retire++;
    checks++; if (sp_data !== 16'h7F10) begin fails++; $display("FAIL sp_final got=%h exp=7f10", sp_data); end
    checks++; if (retire_cnt !== 16'(exp_retire)) begin fails++; $display("FAIL sp_retire got=%h exp=%h", retire_cnt, 16'(exp_retire)); end
  endtask

  task automatic test_flush;
    issue(REG_OP_T, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h0, 16'h0001, 16'h0, 16'h0);
    tick();
    checks++; if (t_data !== (BYP ? 16'h0001 : 16'h0000)) begin fails++; $display("FAIL cmp_capture got=%h exp=%h", t_data, BYP ? 16'h0001 : 16'h0000); end
    issue(REG_OP_T, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h0, 16'h0005, 16'h0, 16'h0);
    flush = 1'b1; stall = 1'b1;
    tick(); idle();
    checks++; if (wb_pending !== 1'b0) begin fails++; $display("FAIL flush_pending got=%b exp=0", wb_pending); end
    checks++; if (t_data !== 16'h0000) begin fails++; $display("FAIL flush_t got=%h exp=0000", t_data); end
    tick();
    checks++; if (t_data !== 16'h0000) begin fails++; $display("FAIL flush_t_after got=%h exp=0000", t_data); end
    checks++; if (retire_cnt !== 16'(exp_retire)) begin fails++; $display("FAIL flush_retire got=%h exp=%h", retire_cnt, 16'(exp_retire)); end
  endtask

  task automatic test_stall;
    ra_addr = 3'd1;
    issue(REG_OP_REG, WB_DATA_OP_PC, WB_ADDR_OP_RX, 16'h0100, 16'h0, 16'h0, 16'h0040);
    tick(); idle();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ra_data !== (BYP ? 16'h0040 : 16'h0000)) begin fails++; $display("FAIL stall_r1 cyc=%0d got=%h exp=%h", k, ra_data, BYP ? 16'h0040 : 16'h0000); end
      checks++; if ({wb_pending, retire_cnt} !== {1'b1, 16'(exp_retire)}) begin fails++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", k, {wb_pending, retire_cnt}, {1'b1, 16'(exp_retire)}); end
    end
    stall = 1'b0;
    tick(); exp_retire++;
    checks++; if (ra_data !== 16'h0040) begin fails++; $display("FAIL stall_release got=%h exp=0040", ra_data); end
    checks++; if (retire_cnt !== 16'(exp_retire)) begin fails++; $display("FAIL stall_retire got=%h exp=%h", retire_cnt, 16'(exp_retire)); end
  endtask

  task automatic test_illegal_r0;
    ra_addr = 3'd0; rb_addr = 3'd6;
    issue(REG_OP_REG, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h06D8, 16'h5A5A, 16'h0, 16'h0);
    tick(); idle(); tick(); exp_retire++;
    checks++; if (ra_data !== 16'h5A5A) begin fails++; $display("FAIL illegal_r0 got=%h exp=5a5a", ra_data); end
    checks++; if (rb_data !== 16'h0000) begin fails++; $display("FAIL illegal_r6 got=%h exp=0000", rb_data); end
  endtask

  task automatic test_ih_dependency;
    ra_addr = 3'd2;
    issue(REG_OP_IH, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h0, 16'h00AA, 16'h0, 16'h0);
    tick();
    issue(REG_OP_REG, WB_DATA_OP_IH, WB_ADDR_OP_RX, 16'h0200, 16'h0, 16'h0, 16'h0);
    tick(); idle(); tick(); exp_retire += 2;
    checks++; if (ra_data !== (BYP ? 16'h00AA : 16'h0000)) begin fails++; $display("FAIL mfih_dep got=%h exp=%h", ra_data, BYP ? 16'h00AA : 16'h0000); end
    checks++; if (ih_data !== 16'h00AA) begin fails++; $display("FAIL ih_commit got=%h exp=00aa", ih_data); end
  endtask

  task automatic test_retire_wrap;
    int n;
    n = 16'hFFFF - exp_retire;
    for (int i = 0; i < n; i++) begin
      issue(REG_OP_T, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h0, i[15:0], 16'h0, 16'h0);
      tick();
    end
    idle(); tick();
    checks++; if (retire_cnt !== 16'hFFFF) begin fails++; $display("FAIL retire_max got=%h exp=ffff", retire_cnt); end
    checks++; if (t_data !== 16'(n - 1)) begin fails++; $display("FAIL retire_last_t got=%h exp=%h", t_data, 16'(n - 1)); end
    issue(REG_OP_T, WB_DATA_OP_ALU, WB_ADDR_OP_NOP, 16'h0, 16'h1111, 16'h0, 16'h0);
    tick(); idle(); tick();
    checks++; if (retire_cnt !== 16'h0000) begin fails++; $display("FAIL retire_wrap got=%h exp=0000", retire_cnt); end
    checks++; if (t_data !== 16'h1111) begin fails++; $display("FAIL wrap_t got=%h exp=1111", t_data); end
  endtask

  task automatic test_reset_mid;
    ra_addr = 3'd4; rb_addr = 3'd0;
    issue(REG_OP_REG, WB_DATA_OP_ALU, WB_ADDR_OP_RX, 16'h0400, 16'h9999, 16'h0, 16'h0);
    tick(); idle();
    checks++; if (wb_pending !== 1'b1) begin fails++; $display("FAIL rstmid_pending_pre got=%b exp=1", wb_pending); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (wb_pending !== 1'b0) begin fails++; $display("FAIL rstmid_pending got=%b exp=0", wb_pending); end
    checks++; if (retire_cnt !== 16'h0000) begin fails++; $display("FAIL rstmid_retire got=%h exp=0000", retire_cnt); end
    checks++; if ({ra_data, rb_data, sp_data, ih_data, t_data} !== 80'h0) begin fails++; $display("FAIL rstmid_regs got=%h exp=0", {ra_data, rb_data, sp_data, ih_data, t_data}); end
    tick();
    checks++; if ({ra_data, retire_cnt} !== 32'h0) begin fails++; $display("FAIL rstmid_no_commit got=%h exp=00000000", {ra_data, retire_cnt}); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_sp_back_to_back();
    test_flush();
    test_stall();
    test_illegal_r0();
    test_ih_dependency();
    test_retire_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
